pipe_reg_param: RTL

Parametrised elastic pipeline register: a chain of DEPTH enable-gated register stages, each WIDTH bits wide, with a per-stage valid bit and a valid/ready handshake at both ends. It replaces bare enable registers wherever a datapath needs multi-cycle registering with back-pressure and flush, e.g. between issue and the functional units. A stalled stage holds its data, and empty stages ahead of it fill, so bubbles collapse. A flush discards all in-flight entries.

---
 rtl/pipe_reg_param_pkg.sv | 13 +
 rtl/pipe_reg_param_stage.sv | 65 ++++++
 rtl/pipe_reg_param.sv | 85 ++++++++
 3 files changed

// File: rtl/pipe_reg_param_pkg.sv
// pipe_reg_param shared definitions: default geometry and pipe-control widths.
// Optional occupancy counter is enabled by defining PIPE_REG_PARAM_OCCUPANCY_EN.
package pipe_reg_param_pkg;

    localparam int unsigned PIPE_WIDTH_DEF = 2;
    localparam int unsigned PIPE_DEPTH_DEF = 2;

    // Bits needed to count 0..depth valid entries.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_param_stage.sv
// One elastic stage: enable-gated data register plus valid flop and
// the free/load handshake logic that lets bubbles collapse.
module dff_en #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

module pipe_reg_stage
    import pipe_reg_param_pkg::*;
#(
    parameter int unsigned WIDTH = PIPE_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             drain,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    logic load;

    // drain: the entry held here moves on this cycle
    assign free = !valid || drain;
    assign load = free && up_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (free) begin
            valid <= load;
        end
    end

    dff_en #(
        .WIDTH(WIDTH)
    ) u_data (
        .clk(clk),
        .rst(rst),
        .en (load && !flush),
        .d  (up_data),
        .q  (data)
    );

endmodule

// File: rtl/pipe_reg_param.sv
// Elastic pipeline register: DEPTH stages with valid/ready at both ends and flush.
// Define PIPE_REG_PARAM_OCCUPANCY_EN to add the registered occupancy port.
module pipe_reg_param
    import pipe_reg_param_pkg::*;
#(
    parameter  int unsigned WIDTH = PIPE_WIDTH_DEF,
    parameter  int unsigned DEPTH = PIPE_DEPTH_DEF,
    localparam int unsigned OCC_W = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_PARAM_OCCUPANCY_EN
    ,
    output logic [OCC_W-1:0] occupancy
`endif
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic             drain;
        logic             valid_q;
        logic             free;
        logic [WIDTH-1:0] up_data;
        logic [WIDTH-1:0] data_q;

        if (i == 0) begin : g_head
            assign up_valid = in_valid;
            assign up_data  = in_data;
        end else begin : g_link
            assign up_valid = g_stage[i-1].valid_q;
            assign up_data  = g_stage[i-1].data_q;
        end

        // The ready chain runs combinationally from out_ready to in_ready.
        if (i == DEPTH - 1) begin : g_tail
            assign drain = out_ready && !flush;
        end else begin : g_mid
            assign drain = g_stage[i+1].free;
        end

        pipe_reg_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush   (flush),
            .up_valid(up_valid),
            .up_data (up_data),
            .drain   (drain),
            .valid   (valid_q),
            .data    (data_q),
            .free    (free)
        );
    end

    assign in_ready  = g_stage[0].free && !flush;
    assign out_valid = g_stage[DEPTH-1].valid_q && !flush;
    assign out_data  = g_stage[DEPTH-1].data_q;

`ifdef PIPE_REG_PARAM_OCCUPANCY_EN
    logic acc;
    logic emit;

    assign acc  = in_valid && in_ready;
    assign emit = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occupancy <= '0;
        end else if (acc && !emit) begin
            occupancy <= occupancy + OCC_W'(1);
        end else if (emit && !acc) begin
            occupancy <= occupancy - OCC_W'(1);
        end
    end
`endif

endmodule
